score_display: RTL and testbench

- Reader/consumer end of the maze-dot score interface.
- Takes the 20-bit binary score from the dot/pellet tracker and converts it to 7 BCD digits with a sequential double-dabble engine.
- Commits digits without tearing and renders them as an 8x8-glyph pixel flag for the colour mapper, using the same DrawX/DrawY raster.
- Sits between the dot tracker and the colour mapper.

---
 rtl/score_display.sv | 168 ++++++++++++++++
 tb/tb_score_display.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Purpose: converts the binary score to BCD with a sequential double-dabble and renders it as 8x8 glyphs.
// Latency: capture edge + 20 shift edges, then one commit edge (deferred while the raster is on the digit rows).
// Backpressure: none; score changes while busy are ignored and the latest value is re-captured once idle.
module score_display #(
    parameter logic [9:0] SCORE_X    = 10'd72,
    parameter logic [9:0] SCORE_Y    = 10'd48,
    parameter int         NUM_DIGITS = 7
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [19:0]             score,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic                    is_score,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam int BW = 4 * NUM_DIGITS;

    state_t                state, state_nxt;
    logic [19:0]           conv_src;
    logic [19:0]           shift;
    logic [BW-1:0]         bcd;
    logic [BW-1:0]         bcd_adj;
    logic [4:0]            cnt;
    logic [NUM_DIGITS-1:0] blank;     // bit c set => cell c (0 = most significant) is dark
    logic                  capture, step, commit;
    logic                  in_rows, in_cols;
    logic [5:0]            dx;
    logic [2:0]            dy;
    logic [3:0]            cell_dig;
    logic                  cell_blank;
    logic [7:0]            row_byte;

    // Add 3 to every nibble of 5 or more; done before the shift so no carry can leave a nibble.
    function automatic logic [BW-1:0] bcd_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Leading-zero suppression; the least significant cell always stays visible.
    function automatic logic [NUM_DIGITS-1:0] calc_blank(input logic [BW-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  z;
        z = 1'b1;
        m = '0;
        for (int c = 0; c < NUM_DIGITS; c++) begin
            z    = z & (d[4*(NUM_DIGITS-1-c) +: 4] == 4'd0);
            m[c] = z;
        end
        m[NUM_DIGITS-1] = 1'b0;
        return m;
    endfunction

    // 8x8 digit font, row 0 in the top byte, MSB is the leftmost pixel.
    function automatic logic [7:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
        logic [63:0] g;
        logic [2:0]  ri;
        case (d)
            4'd0:    g = 64'h3C66_6E76_6666_3C00;
            4'd1:    g = 64'h1838_1818_1818_7E00;
            4'd2:    g = 64'h3C66_060C_3060_7E00;
            4'd3:    g = 64'h3C66_061C_0666_3C00;
            4'd4:    g = 64'h0C1C_3C6C_7E0C_0C00;
            4'd5:    g = 64'h7E60_7C06_0666_3C00;
            4'd6:    g = 64'h3C66_607C_6666_3C00;
            4'd7:    g = 64'h7E66_0C18_1818_1800;
            4'd8:    g = 64'h3C66_663C_6666_3C00;
            4'd9:    g = 64'h3C66_663E_0666_3C00;
            default: g = 64'h0;
        endcase
        ri = 3'd7 - r;
        return g[{ri, 3'b000} +: 8];
    endfunction

    assign in_rows = (DrawY >= SCORE_Y) && (DrawY < SCORE_Y + 10'd8);
    assign in_cols = (DrawX >= SCORE_X) && (DrawX < SCORE_X + 10'(8 * NUM_DIGITS));
    assign bcd_adj = bcd_adjust(bcd);
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and datapath strobes; commit waits until the raster leaves the digit rows.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (score != conv_src) begin
                    capture   = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (cnt == 5'd19) state_nxt = COMMIT;
            end
            COMMIT: begin
                if (!in_rows) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble shift engine and committed display registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            conv_src <= '0;
            shift    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            digits   <= '0;
            blank    <= {1'b0, {(NUM_DIGITS-1){1'b1}}};
            done     <= 1'b0;
        end else begin
            done <= commit;
            if (capture) begin
                conv_src <= score;
                shift    <= score;
                bcd      <= '0;
                cnt      <= '0;
            end else if (step) begin
                bcd   <= {bcd_adj[BW-2:0], shift[19]};
                shift <= {shift[18:0], 1'b0};
                cnt   <= cnt + 5'd1;
            end
            if (commit) begin
                digits <= bcd;
                blank  <= calc_blank(bcd);
            end
        end
    end

    // Pixel lookup from committed state: cell from column bits [5:3], glyph bit from [2:0].
    always_comb begin
        dx         = 6'(DrawX - SCORE_X);
        dy         = 3'(DrawY - SCORE_Y);
        cell_dig   = 4'd0;
        cell_blank = 1'b1;
        for (int c = 0; c < NUM_DIGITS; c++) begin
            if (dx[5:3] == c[2:0]) begin
                cell_dig   = digits[4*(NUM_DIGITS-1-c) +: 4];
                cell_blank = blank[c];
            end
        end
        row_byte = glyph_row(cell_dig, dy);
        is_score = in_rows & in_cols & ~cell_blank & row_byte[~dx[2:0]];
    end

endmodule

// File: tb/tb_score_display.sv
// Purpose: directed checks of score_display conversion, commit timing, blanking and glyph output.
// Latency: expects done visible one cycle after the 22nd edge counted from the capture edge.
// Backpressure: none exercised beyond the commit hold on the digit rows.
module tb_score_display;

    localparam logic [9:0]  SX = 10'd72;
    localparam logic [9:0]  SY = 10'd48;
    localparam logic [63:0] G0 = 64'h3C666E7666663C00;
    localparam logic [63:0] G1 = 64'h1838181818187E00;

    logic        Clk;
    logic        Reset;
    logic [19:0] score;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        is_score;
    logic [27:0] digits;
    logic        busy;
    logic        done;

    int n_vec;
    int n_bad;
    int done_cnt;

    typedef struct {
        logic [19:0] score;
        logic [27:0] exp_digits;
        logic [6:0]  exp_blank;   // bit c set => cell c dark
    } vec_t;

    vec_t vt[8];

    score_display #(.SCORE_X(SX), .SCORE_Y(SY), .NUM_DIGITS(7)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .score    (score),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .is_score (is_score),
        .digits   (digits),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(negedge Clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int cyc;
        bit got;
        cyc = 0;
        got = 0;
        while (!got && cyc < max_cyc) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            if (done === 1'b1) got = 1;
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s: done got 0 within %0d cycles, expected 1", name, max_cyc);
        end
    endtask

    task automatic scan_cell(input int c, output logic [63:0] img);
        img = '0;
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b < 8; b++) begin
                DrawX = SX + 10'(8 * c + b);
                DrawY = SY + 10'(r);
                #1;
                img[63 - (r * 8 + b)] = is_score;
            end
        end
    endtask

    initial begin
        logic [63:0] img;
        logic [7:0]  row_bits;
        logic [22:0] bv, dv;
        logic [27:0] dig20, dig21, ed;
        logic [3:0]  d;
        bit          busy_seen;
        int          d0;

        n_vec    = 0;
        n_bad    = 0;
        done_cnt = 0;

        vt[0] = '{20'd1048575, 28'h1048575, 7'b0000000};
        vt[1] = '{20'd0,       28'h0000000, 7'b0111111};
        vt[2] = '{20'd999,     28'h0000999, 7'b0001111};
        vt[3] = '{20'd123456,  28'h0123456, 7'b0000001};
        vt[4] = '{20'd1000000, 28'h1000000, 7'b0000000};
        vt[5] = '{20'd5,       28'h0000005, 7'b0111111};
        vt[6] = '{20'd524288,  28'h0524288, 7'b0000001};
        vt[7] = '{20'd100,     28'h0000100, 7'b0001111};

        // Reset state and the "0" shown in the least significant cell.
        Reset = 1'b1;
        score = 20'd0;
        DrawX = 10'd0;
        DrawY = SY;
        repeat (3) @(negedge Clk);
        check("reset_digits", 64'(digits), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        for (int b = 0; b < 8; b++) begin
            DrawX = SX + 10'(48 + b);
            DrawY = SY;
            #1;
            row_bits[7 - b] = is_score;
        end
        check("reset_row0_cell6", 64'(row_bits), 64'h3C);
        for (int c = 0; c < 6; c++) begin
            scan_cell(c, img);
            check($sformatf("reset_cell%0d_dark", c), img, 64'h0);
        end
        scan_cell(6, img);
        check("reset_cell6_glyph0", img, G0);
        @(negedge Clk);
        Reset = 1'b0;
        DrawY = 10'd0;
        busy_seen = 0;
        d0 = done_cnt;
        repeat (30) begin
            @(negedge Clk);
            if (busy === 1'b1) busy_seen = 1;
        end
        #1;
        check("idle_zero_busy", 64'(busy_seen), 64'h0);
        check("idle_zero_done_pulses", 64'(done_cnt - d0), 64'h0);

        // Cycle-accurate 0 -> 10 conversion with the raster off the strip.
        @(negedge Clk);
        score = 20'd10;
        DrawY = 10'd0;
        for (int k = 0; k < 23; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            bv[k] = busy;
            dv[k] = done;
            if (k == 20) dig20 = digits;
            if (k == 21) dig21 = digits;
        end
        check("lat_busy_profile", 64'(bv), 64'h1FFFFF);
        check("lat_done_profile", 64'(dv), 64'h200000);
        check("lat_digits_before_commit", 64'(dig20), 64'h0);
        check("lat_digits_after_commit", 64'(dig21), 64'h10);

        // Table of values: digits, blanking and per-cell glyph content.
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            score = vt[i].score;
            DrawX = 10'd0;
            DrawY = 10'd0;
            wait_done($sformatf("vec%0d_done", i), 60);
            check($sformatf("vec%0d_digits", i), 64'(digits), 64'(vt[i].exp_digits));
            ed = vt[i].exp_digits;
            for (int c = 0; c < 7; c++) begin
                scan_cell(c, img);
                d = ed[4 * (6 - c) +: 4];
                if (vt[i].exp_blank[c]) begin
                    check($sformatf("vec%0d_cell%0d_blank", i, c), img, 64'h0);
                end else if (d == 4'd0) begin
                    check($sformatf("vec%0d_cell%0d_glyph0", i, c), img, G0);
                end else if (d == 4'd1) begin
                    check($sformatf("vec%0d_cell%0d_glyph1", i, c), img, G1);
                end else begin
                    check($sformatf("vec%0d_cell%0d_lit", i, c), 64'(img != 64'h0), 64'h1);
                    check($sformatf("vec%0d_cell%0d_row7", i, c), 64'(img[7:0]), 64'h0);
                end
            end
        end

        // Region edges: just right of the strip and just below it.
        DrawX = SX + 10'd56;
        DrawY = SY + 10'd1;
        #1;
        check("outside_right", 64'(is_score), 64'h0);
        DrawX = SX + 10'd50;
        DrawY = SY + 10'd8;
        #1;
        check("outside_below", 64'(is_score), 64'h0);

        // Commit held while the raster is on the digit rows.
        @(negedge Clk);
        d0 = done_cnt;
        score = 20'd4321;
        DrawX = 10'd0;
        DrawY = SY + 10'd2;
        repeat (30) @(negedge Clk);
        #1;
        check("hold_busy", 64'(busy), 64'h1);
        check("hold_digits_unchanged", 64'(digits), 64'h100);
        check("hold_no_done", 64'(done_cnt - d0), 64'h0);
        DrawY = SY + 10'd8;
        @(posedge Clk);
        @(negedge Clk);
        check("hold_release_done", 64'(done), 64'h1);
        check("hold_release_digits", 64'(digits), 64'h4321);
        @(negedge Clk);
        check("hold_done_one_cycle", 64'(done), 64'h0);

        // Score change mid-conversion: first value commits, then the new one is re-captured.
        DrawY = 10'd0;
        d0 = done_cnt;
        score = 20'd10;
        @(posedge Clk);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        score = 20'd60;
        wait_done("midchg_first_done", 60);
        check("midchg_first_digits", 64'(digits), 64'h10);
        wait_done("midchg_second_done", 60);
        check("midchg_second_digits", 64'(digits), 64'h60);
        repeat (30) @(negedge Clk);
        #1;
        check("midchg_done_pulses", 64'(done_cnt - d0), 64'h2);
        check("midchg_idle", 64'(busy), 64'h0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge Clk);
        score = 20'd777;
        @(posedge Clk);
        repeat (10) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("areset_digits", 64'(digits), 64'h0);
        check("areset_busy", 64'(busy), 64'h0);
        check("areset_done", 64'(done), 64'h0);
        @(negedge Clk);
        score = 20'd50;
        @(negedge Clk);
        Reset = 1'b0;
        wait_done("areset_restart_done", 60);
        check("areset_restart_digits", 64'(digits), 64'h50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
